// File: rtl/dmem.sv
// dmem: byte-addressable, little-endian data memory with a valid/ready
// request channel and a valid/ready response channel.
//
// Each request passes through IDLE -> ACCESS -> RESP. The request is latched
// on the acceptance edge, and the access happens on the next edge. The
// response then stays on the outputs until the initiator consumes it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  block can accept (IDLE only)
//   addr       byte address               wdata      store data (LSB-aligned)
//   we         1 store / 0 load           sext       sign-extend byte/half loads
//   width      00 byte, 01 half, 10 word, 11 illegal
//   rsp_valid  response present           rsp_ready  initiator consumes response
//   rdata      load result (0 for stores and errors)
//   rsp_err    request rejected (misaligned, illegal width, out of range)
module dmem #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        sext,
  input  logic [1:0]  width,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rdata_r;
  logic        rsp_err_r;

  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;
  logic        sext_r;
  logic [1:0]  width_r;

  // Storage is deliberately not reset.
  logic [31:0] mem_r [DEPTH_WORDS];

  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic          err_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   sh_s;
  logic [31:0]   load_s;
  logic [3:0]    ben_s;
  logic [31:0]   wdata_s;
  logic          mem_we_s;

  // Replicate store data across all lanes; the byte enables pick the lanes that are written.
  function automatic logic [31:0] lane_data(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  assign idx_s  = addr_r[AW+1:2];
  assign lane_s = addr_r[1:0];

  // Decode the latched request: error check, byte enables, load alignment and extension.
  always_comb begin
    err_s     = 1'b0;
    ben_s     = 4'b0000;
    load_s    = 32'h0000_0000;
    rd_word_s = mem_r[idx_s];
    sh_s      = rd_word_s >> {lane_s, 3'b000};
    wdata_s   = lane_data(width_r, wdata_r);
    case (width_r)
      2'b00: begin
        err_s  = 1'b0;
        ben_s  = 4'b0001 << lane_s;
        load_s = sext_r ? {{24{sh_s[7]}}, sh_s[7:0]} : {24'h00_0000, sh_s[7:0]};
      end
      2'b01: begin
        err_s  = addr_r[0];
        ben_s  = 4'b0011 << {lane_s[1], 1'b0};
        load_s = sext_r ? {{16{sh_s[15]}}, sh_s[15:0]} : {16'h0000, sh_s[15:0]};
      end
      2'b10: begin
        err_s  = (lane_s != 2'b00);
        ben_s  = 4'b1111;
        load_s = sh_s;
      end
      default: begin
        err_s  = 1'b1;
        ben_s  = 4'b0000;
        load_s = 32'h0000_0000;
      end
    endcase
    // Addresses beyond the array alias in idx_s, but the range check rejects them here.
    if (addr_r[31:2] >= DEPTH_W30) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // Reset forces the FSM out of ACCESS at once, so a reset during ACCESS never writes.
  assign mem_we_s = (state_r == ACCESS) && we_r && !err_s;

  // Storage write port: update only the enabled byte lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && ben_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      we_r        <= 1'b0;
      sext_r      <= 1'b0;
      width_r     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            addr_r      <= addr;
            wdata_r     <= wdata;
            we_r        <= we;
            sext_r      <= sext;
            width_r     <= width;
            req_ready_r <= 1'b0;
            state_r     <= ACCESS;
          end else begin
            // req_ready rises here on the first edge after reset is released.
            req_ready_r <= 1'b1;
          end
        end
        ACCESS: begin
          rdata_r     <= (err_s || we_r) ? 32'h0000_0000 : load_s;
          rsp_err_r   <= err_s;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          // A request cannot be accepted in the consume cycle because req_ready is still 0 there.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rdata     = rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem.sv
module tb_dmem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic        sext = 1'b0;
  logic [1:0]  width = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  dmem #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .we(we), .sext(sext), .width(width),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] wd;
    logic        w;
    logic        s;
    logic [1:0]  wid;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] a, input logic [31:0] wd, input logic w,
                     input logic s, input logic [1:0] wid, input logic [31:0] erd, input logic eer);
    vec_t v;
    v.name = n; v.a = a; v.wd = wd; v.w = w; v.s = s; v.wid = wid;
    v.exp_rd = erd; v.exp_err = eer;
    vecs.push_back(v);
  endtask

  // Issue one request, check the 2-edge latency, return the response and consume it.
  task automatic xact(input string n, input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input logic s, input logic [1:0] wid,
                      output logic [31:0] rd, output logic er);
    int k;
    int lat;
    addr = a; wdata = wd; we = w; sext = s; width = wid;
    req_valid = 1'b1; rsp_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk({n, " ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the block must ignore them.
    req_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    we = ~w; sext = ~s; width = 2'b11;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({n, " latency"}, 32'(lat), 32'd2);
    rd = rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({n, " rsp drop"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] held;

    // Reset state
    #2;
    chk("rst req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rel req_ready before edge", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rel req_ready after edge", {31'h0, req_ready}, 32'h1);

    // Directed vectors: {name, addr, wdata, we, sext, width, exp rdata, exp err}
    add("clr w10",     32'h10, 32'h0000_0000, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    add("sb 11",       32'h11, 32'hAAAA_AA80, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    add("lb 11 s",     32'h11, 32'h0,         1'b0, 1'b1, 2'b00, 32'hFFFF_FF80, 1'b0);
    add("lbu 11",      32'h11, 32'h0,         1'b0, 1'b0, 2'b00, 32'h0000_0080, 1'b0);
    add("lw 10 a",     32'h10, 32'h0,         1'b0, 1'b1, 2'b10, 32'h0000_8000, 1'b0);
    add("sw 10",       32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    add("lw 10 b",     32'h10, 32'h0,         1'b0, 1'b0, 2'b10, 32'hDEAD_BEEF, 1'b0);
    add("sw 10 cafe",  32'h10, 32'hCAFE_F00D, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    add("lh 12 s",     32'h12, 32'h0,         1'b0, 1'b1, 2'b01, 32'hFFFF_CAFE, 1'b0);
    add("lhu 12",      32'h12, 32'h0,         1'b0, 1'b0, 2'b01, 32'h0000_CAFE, 1'b0);
    add("lh 10 s",     32'h10, 32'h0,         1'b0, 1'b1, 2'b01, 32'hFFFF_F00D, 1'b0);
    add("lbu 13",      32'h13, 32'h0,         1'b0, 1'b0, 2'b00, 32'h0000_00CA, 1'b0);
    add("lb 10 s",     32'h10, 32'h0,         1'b0, 1'b1, 2'b00, 32'h0000_000D, 1'b0);
    add("sh 12",       32'h12, 32'h1234_5678, 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
    add("lw 10 c",     32'h10, 32'h0,         1'b0, 1'b0, 2'b10, 32'h5678_F00D, 1'b0);
    add("sw 13 mis",   32'h13, 32'h1111_1111, 1'b1, 1'b0, 2'b10, 32'h0, 1'b1);
    add("sw 12 mis",   32'h12, 32'h2222_2222, 1'b1, 1'b0, 2'b10, 32'h0, 1'b1);
    add("sh 11 mis",   32'h11, 32'h3333_3333, 1'b1, 1'b0, 2'b01, 32'h0, 1'b1);
    add("lh 01 mis",   32'h01, 32'h0,         1'b0, 1'b1, 2'b01, 32'h0, 1'b1);
    add("lw 11 ill",   32'h10, 32'h0,         1'b0, 1'b0, 2'b11, 32'h0, 1'b1);
    add("sw 11 ill",   32'h10, 32'h4444_4444, 1'b1, 1'b0, 2'b11, 32'h0, 1'b1);
    add("sw oor",      32'h400, 32'h5555_5555, 1'b1, 1'b0, 2'b10, 32'h0, 1'b1);
    add("lw oor",      32'h400, 32'h0,        1'b0, 1'b0, 2'b10, 32'h0, 1'b1);
    add("sb hi oor",   32'h8000_0010, 32'h66, 1'b1, 1'b0, 2'b00, 32'h0, 1'b1);
    add("sw last",     32'h3FC, 32'h0102_0304, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0);
    add("lw last",     32'h3FC, 32'h0,        1'b0, 1'b0, 2'b10, 32'h0102_0304, 1'b0);
    add("lw 10 keep",  32'h10, 32'h0,         1'b0, 1'b1, 2'b10, 32'h5678_F00D, 1'b0);

    foreach (vecs[i]) begin
      xact(vecs[i].name, vecs[i].a, vecs[i].wd, vecs[i].w, vecs[i].s, vecs[i].wid, rd, er);
      chk({vecs[i].name, " rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, " err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
    end

    // Backpressure: hold rsp_ready low 5 cycles in RESP.
    addr = 32'h10; we = 1'b0; sext = 1'b0; width = 2'b10; req_valid = 1'b1;
    chk("bp ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp valid", {31'h0, rsp_valid}, 32'h1);
    held = rdata;
    chk("bp rdata", held, 32'h5678_F00D);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp hold rdata", rdata, held);
      chk("bp hold ready", {31'h0, req_ready}, 32'h0);
    end
    // Keep req_valid high through the consume edge: it must not be accepted there.
    req_valid = 1'b1; addr = 32'h3FC;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("bp consumed", {31'h0, rsp_valid}, 32'h0);
    chk("bp idle ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("bp no accept", {31'h0, req_ready}, 32'h1);

    // Reset during ACCESS on a load: response is dropped.
    addr = 32'h10; we = 1'b0; width = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("racc ready", {31'h0, req_ready}, 32'h0);
    chk("racc valid", {31'h0, rsp_valid}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("racc valid hold", {31'h0, rsp_valid}, 32'h0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("racc rel ready", {31'h0, req_ready}, 32'h1);
    chk("racc rel valid", {31'h0, rsp_valid}, 32'h0);

    // Reset during ACCESS on a store: the write must not happen.
    addr = 32'h10; wdata = 32'hFFFF_FFFF; we = 1'b1; width = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact("racc reread", 32'h10, 32'h0, 1'b0, 1'b0, 2'b10, rd, er);
    chk("racc data", rd, 32'h5678_F00D);
    chk("racc err", {31'h0, er}, 32'h0);
    xact("racc last", 32'h3FC, 32'h0, 1'b0, 1'b0, 2'b10, rd, er);
    chk("racc last data", rd, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, sets the number of 32-bit storage words (power of two).
REQ-002 Port clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port req_valid  in  1  initiator presents a request.
REQ-005 Port req_ready  out  1  block accepts a request this cycle.
REQ-006 Port addr  in  32  byte address.
REQ-007 Port wdata  in  32  store data; the least-significant bytes are used for byte and half stores.
REQ-008 Port we  in  1  1 = store, 0 = load.
REQ-009 Port sext  in  1  1 = sign-extend load result, 0 = zero-extend.
REQ-010 Port width  in  2  access width: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 Port rsp_valid  out  1  response present.
REQ-012 Port rsp_ready  in  1  initiator consumes the response.
REQ-013 Port rdata  out  32  load result; 0 for stores and errors.
REQ-014 Port rsp_err  out  1  request was rejected (misaligned, illegal width or out of range).

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 When req_valid&&req_ready is 1 at a rising edge, the block SHALL latch addr, wdata, we, sext and width, and move IDLE->ACCESS.
REQ-017 At the following edge the block SHALL perform the access, register rdata and rsp_err, and move ACCESS->RESP.
REQ-018 In RESP, rsp_valid SHALL be 1 and rdata/rsp_err SHALL be held stable until an edge with rsp_ready=1, which moves RESP->IDLE.
REQ-019 Minimum latency from the acceptance edge to rsp_valid high SHALL be exactly 2 edges; peak throughput SHALL be one request per 3 cycles.
REQ-020 No new request SHALL be accepted in the same cycle a response is consumed.
REQ-021 Storage SHALL be little-endian; word index = addr[31:2], byte lane = addr[1:0].
REQ-022 A store SHALL update only the addressed lanes: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and addr[1]*2+1; word -> all four lanes.
REQ-023 A load SHALL right-align the addressed byte/half and extend it to 32 bits per sext; a word load SHALL ignore sext.
REQ-024 rsp_err SHALL be set in each of these cases:
- width=11;
- half with addr[0]=1;
- word with addr[1:0]!=00;
- addr[31:2] >= DEPTH_WORDS.
REQ-025 On rsp_err=1 the block SHALL NOT modify storage, and rdata SHALL be 0.
REQ-026 A store SHALL produce a response (write ack) with rdata=0 and rsp_err as computed.
REQ-027 A load issued after a store to the same word SHALL return the post-store value; no bypass hazard SHALL exist.
REQ-028 Inputs other than rsp_ready SHALL be ignored outside the acceptance edge.

Reset
REQ-029 Asserting reset SHALL immediately force the FSM to IDLE, and set rsp_valid=0, rdata=0, rsp_err=0, req_ready=0.
REQ-030 req_ready SHALL rise in the first cycle after reset deasserts.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 A request in ACCESS when reset asserts SHALL be dropped; its store SHALL NOT complete unless the storage write edge preceded the reset assertion.

Verification
REQ-033 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 edges after each acceptance.
REQ-034 Byte store 0x80 to 0x11 over 0x00000000, then byte load sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080; word load -> 0x00008000.
REQ-035 Half load of 0x12 over 0xCAFEF00D with sext=1 -> 0xFFFFCAFE; with sext=0 -> 0x0000CAFE.
REQ-036 Error cases -> rsp_err=1, rdata=0, storage unchanged on re-read:
- word store to 0x13;
- half load at 0x01;
- width=11;
- addr=DEPTH_WORDS*4.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable and req_ready=0 throughout; RESP->IDLE on the first rsp_ready=1 edge.
REQ-038 Assert reset while in ACCESS on a load -> rsp_valid never rises; after release, req_ready=1 and previously stored data is intact.
